ic1337_seq_detector: RTL
========================

# ic1337_seq_detector

Downstream consumer of the ic1337 flip-flop circuit. It samples the circuit's state outputs Q1/Q0 and its Z output on every rising clock edge. It detects the 2-bit state walk 00 → 01 → 11 → 10, reports each completed walk with a one-cycle pulse, and counts completed walks. When the history feature is compiled in, it also exposes the last four sampled states.

## Interface
Parameters:
- CNT_W, 8: width of the completed-walk counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample enable. When 0, the FSM, counter and history hold.
- q0  input  1  ic1337 Q0.
- q1  input  1  ic1337 Q1.
- z  input  1  ic1337 Z. Abort qualifier.
- clr  input  1  synchronous counter clear.
- hit  output  1  one-cycle pulse, registered, on walk completion.
- hit_count  output  CNT_W  number of completed walks; saturating.
- busy  output  1  high when the FSM is not in IDLE.
- hist  output  8  last four symbols. Newest symbol is in [1:0].

## Operation
- Symbol sym = {q1,q0}, sampled on each rising clk edge with en=1.
- FSM states: IDLE, S1 (seen 00), S2 (seen 00,01), S3 (seen 00,01,11). Transitions on sampled edges with en=1 and z=0:
  - IDLE: sym 00 → S1; any other symbol → IDLE.
  - S1: 01 → S2; 00 → S1; any other symbol → IDLE.
  - S2: 11 → S3; 00 → S1; any other symbol → IDLE.
  - S3: 10 → IDLE and hit; 00 → S1; any other symbol → IDLE.
- z=1 with en=1: FSM → IDLE and no hit, even when sym completes the walk. z does not block counter clear or history shift.
- en=0: FSM, hit_count and hist hold. hit=0.
- hit_count increments by 1 on every hit. It saturates at 2^CNT_W−1 and never wraps.
- clr=1: hit_count → 0 on that edge. clr has priority over a simultaneous increment, but hit is still pulsed. clr does not affect the FSM or hist.
- History (when compiled in): on every en=1 edge, hist ← {hist[5:0], sym}.

## Timing
- Reset values (asynchronous, immediate on rst rising): FSM=IDLE, hit=0, hit_count=0, busy=0, hist=8'h00.
- Reset asserted mid-walk discards the partial walk. The first edge after rst deasserts is treated as a fresh IDLE sample.
- Latency: hit is high for exactly the cycle following the edge that sampled the final 10. hit_count shows the incremented value in that same cycle.
- busy is registered from the FSM state and has no combinational path from the inputs.
- Back-to-back walks: minimum spacing is 4 sampled symbols, giving at most one hit per 4 enabled cycles.
- The inputs come from ic1337, which is synchronous to the same clk. No input synchronizers are used.

## Configuration
- IC1337_SEQ_HISTORY_EN defined: the hist shift register is implemented as described above.
- IC1337_SEQ_HISTORY_EN undefined: no history flops are built and hist is tied to 8'h00. FSM, hit and counter behaviour is identical in both builds.

## Structure
- Package ic1337_pkg holds:
  - the FSM state enum (IDLE, S1, S2, S3, 2-bit encoding);
  - symbol constants SYM_A=2'b00, SYM_B=2'b01, SYM_C=2'b11, SYM_D=2'b10;
  - the history depth constant HIST_DEPTH=4.
- One sub-module, ic1337_hist_sr: a parameterised shift register with enable and async reset. It is instantiated only under IC1337_SEQ_HISTORY_EN.
- The FSM and the saturating counter stay in the top module.

## Test plan
- Reset check: assert rst mid-cycle with hit_count=5 → hit_count=0, busy=0 and hist=8'h00 immediately, without waiting for a clk edge.
- Basic walk: en=1, z=0, symbols 00,01,11,10 → hit=1 for the one cycle after the 4th edge, hit_count=1, and hist=8'b00_01_11_10 (HISTORY_EN build).
- Abort and restart:
  - z=1 on the 11 of the walk 00,01,11,10 → no hit and hit_count unchanged.
  - Then the sequence 00,00,01,11,10 → exactly one hit, on the last symbol.
- en gating: walk 00,01 with en=0 for 3 cycles between symbols, then 11,10 → hit on 10. State and hist are held during the en=0 cycles.
- Saturation with CNT_W=2: drive 5 walks → hit_count reads 1,2,3,3,3.
- Clear collision: clr=1 on the same edge as a completing 10 → hit=1 and hit_count=0. The next walk gives hit_count=1.

Source files
------------

// File: rtl/ic1337_pkg.sv
// Shared types and constants for the ic1337 state-walk detector.
// The walk being detected is SYM_A -> SYM_B -> SYM_C -> SYM_D.
package ic1337_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    S1   = 2'b01,
    S2   = 2'b10,
    S3   = 2'b11
  } state_e;

  localparam logic [1:0] SYM_A = 2'b00;
  localparam logic [1:0] SYM_B = 2'b01;
  localparam logic [1:0] SYM_C = 2'b11;
  localparam logic [1:0] SYM_D = 2'b10;

  localparam int HIST_DEPTH = 4;

endpackage

// File: rtl/ic1337_hist_sr.sv
// Symbol history shift register: the newest symbol enters at the LSBs.
// DEPTH symbols of SYM_W bits each; DEPTH must be at least 2.
module ic1337_hist_sr #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [SYM_W-1:0]       sym_i,
  output logic [SYM_W*DEPTH-1:0] hist_o
);

  logic [SYM_W*DEPTH-1:0] sr_q;
  logic [SYM_W*DEPTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (en_i) begin
      sr_d = {sr_q[SYM_W*(DEPTH-1)-1:0], sym_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign hist_o = sr_q;

endmodule

// File: rtl/ic1337_seq_detector.sv
// Detects the {q1,q0} walk 00->01->11->10 from ic1337, pulses hit and counts walks.
// Optional history output is built only when IC1337_SEQ_HISTORY_EN is defined.
module ic1337_seq_detector
  import ic1337_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             q0,
  input  logic             q1,
  input  logic             z,
  input  logic             clr,
  output logic             hit,
  output logic [CNT_W-1:0] hit_count,
  output logic             busy,
  output logic [7:0]       hist
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       sym;
  state_e           state_q;
  state_e           state_d;
  logic             hit_q;
  logic             hit_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign sym = {q1, q0};

  // A fresh SYM_A always restarts the walk, whatever partial progress existed.
  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    if (en) begin
      if (z) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: state_d = (sym == SYM_A) ? S1 : IDLE;
          S1: begin
            if (sym == SYM_B)      state_d = S2;
            else if (sym == SYM_A) state_d = S1;
            else                   state_d = IDLE;
          end
          S2: begin
            if (sym == SYM_C)      state_d = S3;
            else if (sym == SYM_A) state_d = S1;
            else                   state_d = IDLE;
          end
          S3: begin
            if (sym == SYM_D) begin
              state_d = IDLE;
              hit_d   = 1'b1;
            end else if (sym == SYM_A) begin
              state_d = S1;
            end else begin
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Clear wins over a coincident increment; the counter sticks at its maximum.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (hit_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hit       = hit_q;
  assign hit_count = cnt_q;
  assign busy      = (state_q != IDLE);

`ifdef IC1337_SEQ_HISTORY_EN
  ic1337_hist_sr #(
    .SYM_W (2),
    .DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en),
    .sym_i  (sym),
    .hist_o (hist)
  );
`else
  assign hist = 8'h00;
`endif

endmodule
